// File: rtl/mm_bus_pkg.sv
// Shared types and defaults for the multi-master memory-mapped interconnect.
package mm_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } mm_state_e;

   localparam int MM_MASTERS = 2;
   localparam int MM_REGIONS = 4;
   localparam int MM_AW      = 32;
   localparam int MM_DW      = 32;
   localparam int MM_TIMEOUT = 255;

   // Builds an exclusive region end from a base and a byte size (wraps mod 2^AW).
   function automatic logic [MM_AW-1:0] mm_region_end(input logic [MM_AW-1:0] base,
                                                      input logic [MM_AW-1:0] size);
      return base + size;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or above the
// pointer wins, wrapping back to index 0.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] rr_ptr_i,
   output logic          gnt_vld_o,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] gnt_idx_o
);

   // Scan upward from the pointer; the first requester seen takes the grant.
   always_comb begin
      logic [IW-1:0] cand;
      gnt_vld_o = 1'b0;
      gnt_o     = '0;
      gnt_idx_o = '0;
      cand      = '0;
      for (int off = 0; off < N; off++) begin
         cand = IW'((int'(rr_ptr_i) + off) % N);
         if (!gnt_vld_o && req_i[cand]) begin
            gnt_vld_o     = 1'b1;
            gnt_idx_o     = cand;
            gnt_o[cand]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mm_interconnect.sv
// Multi-master, multi-region memory-mapped interconnect. One transaction in
// flight: arbitrate + decode in IDLE, drive the slave in ACCESS, answer the
// master in RESP. Misses and slave timeouts complete with an error.
module mm_interconnect
   import mm_bus_pkg::*;
#(
   parameter int MASTERS = MM_MASTERS,
   parameter int REGIONS = MM_REGIONS,
   parameter int AW      = MM_AW,
   parameter int DW      = MM_DW,
   parameter int TIMEOUT = MM_TIMEOUT
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [MASTERS-1:0]              m_req,
   input  logic [MASTERS-1:0]              m_we,
   input  logic [MASTERS-1:0][AW-1:0]      m_addr,
   input  logic [MASTERS-1:0][DW-1:0]      m_wd,
   output logic [MASTERS-1:0]              m_ack,
   output logic                            m_err,
   output logic [DW-1:0]                   m_rd,
   input  logic [REGIONS-1:0][AW-1:0]      region_base,
   input  logic [REGIONS-1:0][AW-1:0]      region_end,
   output logic [REGIONS-1:0]              s_req,
   output logic                            s_we,
   output logic [AW-1:0]                   s_addr,
   output logic [DW-1:0]                   s_wd,
   input  logic [REGIONS-1:0][DW-1:0]      s_rd,
   input  logic [REGIONS-1:0]              s_ack
);

   localparam int MIW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam int RIW = (REGIONS > 1) ? $clog2(REGIONS) : 1;
   localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   mm_state_e            state_q;
   logic [MIW-1:0]       rr_ptr_q;
   logic [MIW-1:0]       grant_q;
   logic [RIW-1:0]       sel_q;
   logic [CW-1:0]        tmo_q;
   logic [MASTERS-1:0]   m_ack_q;
   logic                 m_err_q;
   logic [DW-1:0]        m_rd_q;
   logic [REGIONS-1:0]   s_req_q;
   logic                 s_we_q;
   logic [AW-1:0]        s_addr_q;
   logic [DW-1:0]        s_wd_q;

   logic                 gnt_vld;
   logic [MASTERS-1:0]   gnt_oh;
   logic [MIW-1:0]       gnt_idx;
   logic [AW-1:0]        arb_addr;
   logic [AW-1:0]        rel_addr;
   logic                 hit;
   logic [RIW-1:0]       hit_idx;

   rr_arbiter #(.N(MASTERS), .IW(MIW)) u_arb (
      .req_i     (m_req),
      .rr_ptr_i  (rr_ptr_q),
      .gnt_vld_o (gnt_vld),
      .gnt_o     (gnt_oh),
      .gnt_idx_o (gnt_idx)
   );

   assign arb_addr = m_addr[gnt_idx];

   // Address decode of the granted request; lowest region index wins on overlap.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int r = 0; r < REGIONS; r++) begin
         if (!hit && arb_addr >= region_base[r] && arb_addr < region_end[r]) begin
            hit     = 1'b1;
            hit_idx = RIW'(r);
         end
      end
   end

   // Slave sees a base-relative address (modulo 2^AW).
   assign rel_addr = arb_addr - region_base[hit_idx];

   // Transaction FSM with registered master and slave side outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         sel_q    <= '0;
         tmo_q    <= '0;
         m_ack_q  <= '0;
         m_err_q  <= 1'b0;
         m_rd_q   <= '0;
         s_req_q  <= '0;
         s_we_q   <= 1'b0;
         s_addr_q <= '0;
         s_wd_q   <= '0;
      end else begin
         m_ack_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (gnt_vld) begin
                  grant_q <= gnt_idx;
                  s_we_q  <= m_we[gnt_idx];
                  s_wd_q  <= m_wd[gnt_idx];
                  if (hit) begin
                     sel_q    <= hit_idx;
                     s_addr_q <= rel_addr;
                     s_req_q  <= REGIONS'(1) << hit_idx;
                     tmo_q    <= '0;
                     state_q  <= ACCESS;
                  end else begin
                     // Decode miss: answer straight away with an error.
                     m_ack_q <= gnt_oh;
                     m_err_q <= 1'b1;
                     m_rd_q  <= '0;
                     state_q <= RESP;
                  end
               end
            end
            ACCESS: begin
               if (s_ack[sel_q]) begin
                  s_req_q <= '0;
                  m_ack_q <= MASTERS'(1) << grant_q;
                  m_err_q <= 1'b0;
                  m_rd_q  <= s_we_q ? '0 : s_rd[sel_q];
                  state_q <= RESP;
               end else if (TIMEOUT != 0 && tmo_q == CW'(TIMEOUT - 1)) begin
                  // Slave never answered: drop the request and report an error.
                  s_req_q <= '0;
                  m_ack_q <= MASTERS'(1) << grant_q;
                  m_err_q <= 1'b1;
                  m_rd_q  <= '0;
                  state_q <= RESP;
               end else begin
                  tmo_q <= tmo_q + CW'(1);
               end
            end
            RESP: begin
               rr_ptr_q <= (grant_q == MIW'(MASTERS - 1)) ? '0 : grant_q + MIW'(1);
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m_ack  = m_ack_q;
   assign m_err  = m_err_q;
   assign m_rd   = m_rd_q;
   assign s_req  = s_req_q;
   assign s_we   = s_we_q;
   assign s_addr = s_addr_q;
   assign s_wd   = s_wd_q;

endmodule

// File: tb/tb_mm_interconnect.sv
// Directed bench for mm_interconnect: two masters, four regions, TIMEOUT=4.
module tb_mm_interconnect;
   import mm_bus_pkg::*;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [1:0]       m_req = '0;
   logic [1:0]       m_we = '0;
   logic [1:0][31:0] m_addr = '0;
   logic [1:0][31:0] m_wd = '0;
   logic [1:0]       m_ack;
   logic             m_err;
   logic [31:0]      m_rd;
   logic [3:0][31:0] region_base;
   logic [3:0][31:0] region_end;
   logic [3:0]       s_req;
   logic             s_we;
   logic [31:0]      s_addr;
   logic [31:0]      s_wd;
   logic [3:0][31:0] s_rd = '0;
   logic [3:0]       s_ack = '0;

   int n_chk  = 0;
   int n_pass = 0;

   mm_interconnect #(
      .MASTERS(2), .REGIONS(4), .AW(32), .DW(32), .TIMEOUT(4)
   ) dut (
      .clk(clk), .reset(reset),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd),
      .m_ack(m_ack), .m_err(m_err), .m_rd(m_rd),
      .region_base(region_base), .region_end(region_end),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wd(s_wd),
      .s_rd(s_rd), .s_ack(s_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction from master m; the target slave acks after 'waits' extra
   // s_req cycles (waits<0: never). noise=1 acks every other region constantly.
   task automatic do_txn(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input int reg_i, input int waits,
                         input logic [31:0] rdata, input logic noise,
                         output int lat, output logic err, output logic [31:0] rd,
                         output int sc, output logic [31:0] sa, output logic stab,
                         output logic [3:0] sreq_or);
      int cyc;
      logic done;
      cyc = 0; sc = 0; done = 1'b0; lat = -1; err = 1'b0; rd = '0;
      sa = '0; stab = 1'b1; sreq_or = '0;
      s_rd = '0;
      s_rd[reg_i] = rdata;
      s_ack = noise ? ~(4'b0001 << reg_i) : 4'b0000;
      m_we[m] = we; m_addr[m] = addr; m_wd[m] = wd; m_req[m] = 1'b1;
      while (!done && cyc < 40) begin
         tick();
         cyc++;
         sreq_or |= s_req;
         if (s_req != 4'b0000) begin
            sc++;
            if (sc == 1) sa = s_addr;
            if (s_addr !== sa || s_we !== we || s_wd !== wd) stab = 1'b0;
         end
         if (m_ack[m]) begin
            lat = cyc; err = m_err; rd = m_rd; done = 1'b1; m_req[m] = 1'b0;
         end
         s_ack = noise ? ~(4'b0001 << reg_i) : 4'b0000;
         if (!done && waits >= 0 && s_req[reg_i] && sc == waits + 1) s_ack[reg_i] = 1'b1;
      end
      if (!done) begin
         chk("txn_budget", 64'd0, 64'd1);
         m_req[m] = 1'b0;
      end
      s_ack = '0;
      tick();
   endtask

   // Both masters request continuously on region 0; records grant order.
   task automatic rr_both(input int n, output logic [3:0] order, output int last);
      int k, cyc;
      k = 0; cyc = 0; order = '0; last = -1;
      m_we = '0; m_addr[0] = 32'h10; m_addr[1] = 32'h20;
      s_rd = '0; s_rd[0] = 32'hA5A5_0000; s_ack = '0;
      m_req = 2'b11;
      while (k < n && cyc < 60) begin
         tick();
         cyc++;
         if (m_ack != 2'b00) begin
            order[k] = m_ack[1];
            k++;
            last = cyc;
            if (k == n) m_req = 2'b00;
         end
         s_ack[0] = s_req[0];
      end
      if (k < n) chk("rr_budget", 64'd0, 64'd1);
      m_req = 2'b00; s_ack = '0;
      tick();
   endtask

   int          lat, sc, last;
   logic        err, stab;
   logic [31:0] rd, sa;
   logic [3:0]  sro, order;

   initial begin
      region_base[0] = 32'h0000; region_end[0] = mm_region_end(32'h0000, 32'h1000);
      region_base[1] = 32'h1000; region_end[1] = mm_region_end(32'h1000, 32'h1000);
      region_base[2] = 32'h2000; region_end[2] = mm_region_end(32'h2000, 32'h1000);
      region_base[3] = 32'h4000; region_end[3] = mm_region_end(32'h4000, 32'h1000);

      // Reset state
      tick(); tick();
      chk("rst_m_ack", 64'(m_ack), 64'd0);
      chk("rst_m_err", 64'(m_err), 64'd0);
      chk("rst_m_rd",  64'(m_rd), 64'd0);
      chk("rst_s_req", 64'(s_req), 64'd0);
      chk("rst_s_we",  64'(s_we), 64'd0);
      chk("rst_s_addr", 64'(s_addr), 64'd0);
      chk("rst_s_wd",  64'(s_wd), 64'd0);
      reset = 1'b1;
      tick();

      // Round robin from pointer 0: 0,1,0,1, one transaction per 3 cycles
      rr_both(4, order, last);
      chk("rr_order", 64'(order), 64'b1010);
      chk("rr_last_cycle", 64'(last), 64'd11);

      // Single read, zero wait
      do_txn(0, 1'b0, 32'h1004, 32'h0, 1, 0, 32'hDEAD_BEEF, 1'b0, lat, err, rd, sc, sa, stab, sro);
      chk("rd_lat", 64'(lat), 64'd2);
      chk("rd_s_addr", 64'(sa), 64'h4);
      chk("rd_data", 64'(rd), 64'hDEAD_BEEF);
      chk("rd_err", 64'(err), 64'd0);
      chk("rd_s_req", 64'(sro), 64'b0010);
      chk("rd_sreq_cycles", 64'(sc), 64'd1);

      // Last word of region 1, one wait state
      do_txn(1, 1'b0, 32'h1FFC, 32'h0, 1, 1, 32'h0BAD_F00D, 1'b0, lat, err, rd, sc, sa, stab, sro);
      chk("top_lat", 64'(lat), 64'd3);
      chk("top_s_addr", 64'(sa), 64'hFFC);
      chk("top_data", 64'(rd), 64'h0BAD_F00D);

      // First byte of region 2 (end is exclusive), other regions ack noise
      do_txn(0, 1'b0, 32'h2000, 32'h0, 2, 0, 32'h5555_AAAA, 1'b1, lat, err, rd, sc, sa, stab, sro);
      chk("edge_s_req", 64'(sro), 64'b0100);
      chk("edge_s_addr", 64'(sa), 64'h0);
      chk("edge_lat", 64'(lat), 64'd2);
      chk("edge_data", 64'(rd), 64'h5555_AAAA);

      // Decode miss
      do_txn(1, 1'b0, 32'h3000, 32'h0, 0, 0, 32'h7777_7777, 1'b0, lat, err, rd, sc, sa, stab, sro);
      chk("miss_lat", 64'(lat), 64'd1);
      chk("miss_err", 64'(err), 64'd1);
      chk("miss_rd", 64'(rd), 64'd0);
      chk("miss_s_req", 64'(sro), 64'd0);

      // Timeout, slave 3 silent while the others ack
      do_txn(0, 1'b0, 32'h4010, 32'h0, 3, -1, 32'h1111_2222, 1'b1, lat, err, rd, sc, sa, stab, sro);
      chk("tmo_sreq_cycles", 64'(sc), 64'd4);
      chk("tmo_lat", 64'(lat), 64'd5);
      chk("tmo_err", 64'(err), 64'd1);
      chk("tmo_rd", 64'(rd), 64'd0);
      s_ack[3] = 1'b1;
      tick();
      s_ack = '0;
      chk("tmo_late_ack", 64'(m_ack), 64'd0);
      chk("tmo_late_sreq", 64'(s_req), 64'd0);

      // Write with three wait states
      do_txn(1, 1'b1, 32'h2010, 32'h1234_5678, 2, 3, 32'hFFFF_FFFF, 1'b0, lat, err, rd, sc, sa, stab, sro);
      chk("wr_sreq_cycles", 64'(sc), 64'd4);
      chk("wr_stable", 64'(stab), 64'd1);
      chk("wr_lat", 64'(lat), 64'd5);
      chk("wr_err", 64'(err), 64'd0);
      chk("wr_rd_zero", 64'(rd), 64'd0);
      chk("wr_s_addr", 64'(sa), 64'h10);

      // Reset during ACCESS with the pointer at 1
      do_txn(0, 1'b0, 32'h0040, 32'h0, 0, 0, 32'h0, 1'b0, lat, err, rd, sc, sa, stab, sro);
      m_we[1] = 1'b0; m_addr[1] = 32'h1000; m_req[1] = 1'b1;
      tick(); tick();
      chk("rst_mid_pre", 64'(s_req), 64'b0010);
      #2 reset = 1'b0;
      #1;
      chk("rst_mid_s_req", 64'(s_req), 64'd0);
      chk("rst_mid_m_ack", 64'(m_ack), 64'd0);
      m_req = '0;
      tick();
      chk("rst_mid_no_ack", 64'(m_ack), 64'd0);
      reset = 1'b1;
      tick();
      rr_both(1, order, last);
      chk("rst_ptr_zero", 64'(order[0]), 64'd0);
      chk("rst_ptr_lat", 64'(last), 64'd2);
      do_txn(1, 1'b0, 32'h1008, 32'h0, 1, 0, 32'hCAFE_F00D, 1'b0, lat, err, rd, sc, sa, stab, sro);
      chk("post_rst_lat", 64'(lat), 64'd2);
      chk("post_rst_data", 64'(rd), 64'hCAFE_F00D);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mm_interconnect.md
# mm_interconnect

Parametrised multi-master, multi-region memory-mapped interconnect; successor to `simple_interconnect`. Arbitrates N bus masters (core data port, DMA, debug) round-robin onto REGIONS address-decoded slaves using a req/ack handshake. Adds slave wait states, decode-error and timeout responses, and base-relative slave addresses. Sits between `core_top` plus other masters and the ROM/RAM/PIO slaves in `top`.

## Interface
- `MASTERS`, 2: number of masters (1..8)
- `REGIONS`, 4: number of slave regions (1..16)
- `AW`, 32: address width
- `DW`, 32: data width
- `TIMEOUT`, 255: max ACCESS cycles before error; 0 disables timeout
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `m_req`  in  MASTERS  request, level, held until `m_ack`
- `m_we`  in  MASTERS  write enable
- `m_addr`  in  MASTERS×AW  byte address
- `m_wd`  in  MASTERS×DW  write data
- `m_ack`  out  MASTERS  one-cycle completion pulse
- `m_err`  out  1  error flag, valid with `m_ack`
- `m_rd`  out  DW  read data, valid with `m_ack`
- `region_base`, `region_end`  in  REGIONS×AW  region bounds, static
- `s_req`  out  REGIONS  one-hot slave request
- `s_we`  out  1  write enable to selected slave
- `s_addr`  out  AW  `m_addr − region_base[sel]`
- `s_wd`  out  DW  write data
- `s_rd`  in  REGIONS×DW  slave read data
- `s_ack`  in  REGIONS  slave completion

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any `m_req`, round-robin arbiter grants lowest index ≥ `rr_ptr` (wrapping). Registers grant, we, addr, wd; decodes region (`base ≤ addr < end`, lowest index wins on overlap). Hit → ACCESS. No hit → RESP with err=1.
- ACCESS: `s_req[sel]`=1; `s_we/s_addr/s_wd` held stable. On `s_ack[sel]`: capture `s_rd[sel]`, err=0 → RESP. Timeout counter increments each ACCESS cycle; reaching TIMEOUT without ack → RESP, err=1, `s_req` dropped. Late `s_ack` ignored.
- RESP: `m_ack[grant]`=1, `m_err`=err, `m_rd`=captured data (0 on error or write). `rr_ptr` ← (grant+1) mod MASTERS. → IDLE.
- Masters drop `m_req` in the cycle after `m_ack`; a request still high in IDLE is a new transaction.
- Ungranted masters wait; no starvation: each waiting master is served within MASTERS transactions.
- Acks on non-selected `s_ack` bits ignored.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, all `m_ack`/`s_req`=0, `m_err`=0, `m_rd`=0, `s_we`=0, `s_addr`=0, `s_wd`=0, timeout counter 0.
- Reset asserted mid-transaction: immediate return to IDLE, `s_req` drops asynchronously; no `m_ack` issued.
- Hit, zero-wait slave: `m_req` cycle 0 → `s_req` cycle 1, `s_ack` cycle 1 → `m_ack` cycle 2. Each slave wait cycle adds 1.
- Decode miss: `m_req` cycle 0 → `m_ack`+`m_err` cycle 1.
- Timeout: `m_ack`+`m_err` at cycle TIMEOUT+1 after `s_req` rises.
- Back-to-back: one transaction in flight; next arbitration in IDLE cycle after RESP (min 3 cycles/transaction).
- Address arithmetic modulo 2^AW; counter width $clog2(TIMEOUT+1).

## Structure
- Package `mm_bus_pkg`: state enum `mm_state_e` (IDLE, ACCESS, RESP), default widths, helper to build region arrays.
- Sub-module `rr_arbiter` (MASTERS-wide request vector, `rr_ptr` in, one-hot grant + index out, combinational); FSM, decode, timeout in `mm_interconnect`.

## Test plan
- Single master read, region 1 base 0x1000, addr 0x1004, slave acks cycle 1 with 0xDEADBEEF → `s_addr`=0x4, `m_ack` cycle 2, `m_rd`=0xDEADBEEF, `m_err`=0.
- Both masters request simultaneously three times, `rr_ptr`=0 → grants order 0,1,0 then 1; no master waits >2 transactions.
- Addr 0x3000 outside all regions → `m_ack`+`m_err` one cycle after request, no `s_req`, `m_rd`=0.
- TIMEOUT=4, slave never acks → `s_req` high 4 cycles, then `m_ack`+`m_err`; late `s_ack` on next cycle has no effect.
- Write 0x12345678 to region 2 with 3 wait states → `s_we`/`s_wd` stable 4 cycles, `m_ack` 5 cycles after request.
- Reset low during ACCESS → `s_req`=0 immediately, no `m_ack`, `rr_ptr`=0; next request completes normally.
